manycore_link_buffer: RTL and testbench

MANYCORE_LINK_BUFFER -- requirements
Module: manycore_link_buffer

---
 rtl/manycore_link_buffer.sv | 143 ++++++++++++++
 tb/tb_manycore_link_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/manycore_link_buffer.sv
// manycore_link_buffer: credit-flow link FIFO between two mesh routers, with an
// output-side packet tracker (HEADER / SIZE / PAYLOAD) and a sticky overflow flag.
// Optional delivery statistics are compiled in with MANYCORE_LINK_STATS_EN.
//
// Handshake: a flit moves upstream->buffer on a rising edge where rx_i and
// credit_o are both 1; it moves buffer->downstream on a rising edge where tx_o
// and credit_i are both 1. credit_o and tx_o depend only on registered state.
module manycore_link_buffer #(
    parameter int FLIT_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_i,
    input  logic [FLIT_WIDTH-1:0] data_i,
    output logic                  credit_o,
    output logic                  tx_o,
    output logic [FLIT_WIDTH-1:0] data_o,
    input  logic                  credit_i,
    output logic                  pkt_busy_o,
    output logic                  overflow_o,
    output logic [31:0]           flit_count_o,
    output logic [15:0]           pkt_count_o,
    output logic [1:0]            fsm_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        SIZE    = 2'd1,
        PAYLOAD = 2'd2
    } pkt_state_e;

    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           occ_q, occ_d;
    logic                  overflow_q;
    pkt_state_e            state_q, state_d;
    logic [FLIT_WIDTH-1:0] remaining_q, remaining_d;
    logic                  push, pop;

    assign credit_o    = (occ_q < OCC_FULL);
    assign tx_o        = (occ_q != '0);
    assign data_o      = tx_o ? mem[rd_ptr_q] : '0;
    assign push        = rx_i & credit_o;
    assign pop         = tx_o & credit_i;
    assign pkt_busy_o  = (state_q != HEADER);
    assign overflow_o  = overflow_q;
    assign fsm_state_o = state_q;

    // Flit storage: written on push only, deliberately not reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // Occupancy next-state: simultaneous push and pop cancel out.
    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Pointers wrap naturally at DEPTH (power of two); overflow is sticky.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q      <= occ_d;
            overflow_q <= overflow_q | (rx_i & ~credit_o);
        end
    end

    // Packet tracker next-state: advances only on a pop.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        if (pop) begin
            case (state_q)
                HEADER: state_d = SIZE;
                SIZE: begin
                    remaining_d = data_o;
                    state_d     = (data_o == '0) ? HEADER : PAYLOAD;
                end
                PAYLOAD: begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == FLIT_WIDTH'(1)) state_d = HEADER;
                end
                default: state_d = HEADER;
            endcase
        end
    end

    // Packet tracker registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= HEADER;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

`ifdef MANYCORE_LINK_STATS_EN
    logic        pkt_end;
    logic [31:0] flit_cnt_q;
    logic [15:0] pkt_cnt_q;

    // A packet ends on a zero-size SIZE pop or on the last PAYLOAD pop.
    assign pkt_end = pop && (((state_q == SIZE) && (data_o == '0)) ||
                             ((state_q == PAYLOAD) && (remaining_q == FLIT_WIDTH'(1))));

    // Wrapping delivery counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            if (pop)     flit_cnt_q <= flit_cnt_q + 1'b1;
            if (pkt_end) pkt_cnt_q  <= pkt_cnt_q + 1'b1;
        end
    end

    assign flit_count_o = flit_cnt_q;
    assign pkt_count_o  = pkt_cnt_q;
`else
    assign flit_count_o = '0;
    assign pkt_count_o  = '0;
`endif

endmodule

// File: tb/tb_manycore_link_buffer.sv
// Bench for manycore_link_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based packet model.
module tb_manycore_link_buffer;

    localparam int FW    = 16;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          rx_i = 1'b0;
    logic [FW-1:0] data_i = '0;
    logic          credit_o;
    logic          tx_o;
    logic [FW-1:0] data_o;
    logic          credit_i = 1'b0;
    logic          pkt_busy_o;
    logic          overflow_o;
    logic [31:0]   flit_count_o;
    logic [15:0]   pkt_count_o;
    logic [1:0]    fsm_state_o;

    manycore_link_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .rx_i(rx_i), .data_i(data_i),
        .credit_o(credit_o), .tx_o(tx_o), .data_o(data_o), .credit_i(credit_i),
        .pkt_busy_o(pkt_busy_o), .overflow_o(overflow_o),
        .flit_count_o(flit_count_o), .pkt_count_o(pkt_count_o),
        .fsm_state_o(fsm_state_o)
    );

    // Clock
    always #5 clock = ~clock;

    // Reference model: flits in arrival order, packet position, sticky flag, counts.
    logic [FW-1:0] exp_q[$];
    int            m_phase;   // 0: next popped flit is a header, 1: a size, 2: payload
    int            m_left;
    bit            m_ovf;
    logic [31:0]   m_flits;
    logic [15:0]   m_pkts;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_phase = 0;
        m_left  = 0;
        m_ovf   = 1'b0;
        m_flits = '0;
        m_pkts  = '0;
    endtask

    task automatic check_outputs();
        logic [FW-1:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : '0;
        check("credit_o",   32'(credit_o),   32'(exp_q.size() < DEPTH));
        check("tx_o",       32'(tx_o),       32'(exp_q.size() > 0));
        check("data_o",     32'(data_o),     32'(head));
        check("pkt_busy_o", 32'(pkt_busy_o), 32'(m_phase != 0));
        check("fsm_state",  32'(fsm_state_o), 32'(m_phase));
        check("overflow_o", 32'(overflow_o), 32'(m_ovf));
`ifdef MANYCORE_LINK_STATS_EN
        check("flit_count", flit_count_o, m_flits);
        check("pkt_count",  32'(pkt_count_o), 32'(m_pkts));
`else
        check("flit_count", flit_count_o, 32'd0);
        check("pkt_count",  32'(pkt_count_o), 32'd0);
`endif
    endtask

    // One clock cycle: drive at negedge, check, then advance the model at posedge.
    task automatic drive_cycle(input bit rx, input logic [FW-1:0] d, input bit cr);
        bit            can_push, can_pop;
        logic [FW-1:0] f;
        @(negedge clock);
        rx_i = rx; data_i = d; credit_i = cr;
        #1;
        check_outputs();
        can_push = rx && (exp_q.size() < DEPTH);
        can_pop  = cr && (exp_q.size() > 0);
        if (rx && !can_push) m_ovf = 1'b1;
        @(posedge clock);
        if (can_pop) begin
            f = exp_q.pop_front();
            m_flits = m_flits + 1;
            if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (f == 0) begin
                    m_phase = 0;
                    m_pkts  = m_pkts + 1;
                end else begin
                    m_left  = int'(f);
                    m_phase = 2;
                end
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_phase = 0;
                    m_pkts  = m_pkts + 1;
                end
            end
        end
        if (can_push) exp_q.push_back(d);
    endtask

    task automatic idle(input int n, input bit cr);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, FW'($urandom_range(0, 65535)), cr);
    endtask

    // Asynchronous reset asserted between edges, checked before any clock edge.
    task automatic apply_reset();
        @(negedge clock);
        #2;
        rx_i = 1'b1; data_i = FW'($urandom_range(0, 65535)); credit_i = 1'b1;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clock);
        rx_i = 1'b0; credit_i = 1'b0;
        reset = 1'b1;
    endtask

    logic [FW-1:0] basic [4];
    logic [FW-1:0] burst [5];

    initial begin
        model_reset();
        basic = '{16'h0011, 16'h0002, 16'hAAAA, 16'hBBBB};
        burst = '{16'h0005, 16'h0003, 16'h1111, 16'h2222, 16'h3333};

        // Reset state with inputs active
        rx_i = 1'b1; data_i = 16'hDEAD; credit_i = 1'b1;
        #3;
        check_outputs();
        @(negedge clock);
        rx_i = 1'b0; credit_i = 1'b0;
        reset = 1'b1;

        // Basic packet through an empty buffer
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, basic[i], 1'b1);
        idle(3, 1'b1);

        // Fill with downstream blocked, fifth flit dropped, then drain
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, burst[i], 1'b0);
        idle(2, 1'b0);
        idle(6, 1'b1);

        // Full buffer: refused flit retried while downstream opens, across wrap
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, FW'(16'h0040 + i), 1'b0);
        drive_cycle(1'b1, 16'h0077, 1'b1);
        drive_cycle(1'b1, 16'h0077, 1'b1);
        drive_cycle(1'b1, 16'h0078, 1'b1);
        idle(6, 1'b1);

        // Random traffic, short packets favoured
        for (int i = 0; i < 400; i++) begin
            logic [FW-1:0] d;
            d = ($urandom_range(0, 1) == 0) ? FW'($urandom_range(0, 3)) : FW'($urandom_range(0, 65535));
            drive_cycle(1'(($urandom_range(0, 3) != 0)), d, 1'(($urandom_range(0, 2) != 0)));
        end
        idle(8, 1'b1);

        // Zero-size packet
        apply_reset();
        drive_cycle(1'b1, 16'h0101, 1'b1);
        drive_cycle(1'b1, 16'h0000, 1'b1);
        idle(4, 1'b1);

        // Reset during PAYLOAD with two flits queued
        drive_cycle(1'b1, 16'h0009, 1'b1);
        drive_cycle(1'b1, 16'h0005, 1'b1);
        drive_cycle(1'b1, 16'h00C1, 1'b1);
        drive_cycle(1'b1, 16'h00C2, 1'b0);
        drive_cycle(1'b0, 16'h0000, 1'b0);
        apply_reset();
        drive_cycle(1'b1, 16'h00AB, 1'b1);
        drive_cycle(1'b1, 16'h0000, 1'b1);
        idle(4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
